iis_sync_fifo: RTL and testbench
================================

# iis_sync_fifo

Single-clock, parametrised sample FIFO for the IIS plug-in path; the next generation of the team's audio-sample buffer. It adds configurable width and depth, a first-word-fall-through (FWFT) mode, an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. It sits between the IIS serialiser/deserialiser and the APB-side register logic where both run on the peripheral clock.

## Interface
- DATA_WIDTH, 16, sample word width
- ADDR_WIDTH, 10, depth = 2**ADDR_WIDTH (power of two only)
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- AFULL_THRESH, 2**ADDR_WIDTH-4, almost_full asserts when level >= this
- AEMPTY_THRESH, 4, almost_empty asserts when level <= this

- clk  in  1  single clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous flush, active-high
- wr_en  in  1  write request
- din  in  DATA_WIDTH  write data
- rd_en  in  1  read request (standard) / pop-acknowledge (FWFT)
- dout  out  DATA_WIDTH  read data
- valid  out  1  dout holds a valid word (see Operation)
- full  out  1  level == DEPTH
- empty  out  1  no readable word
- almost_full  out  1  level >= AFULL_THRESH
- almost_empty  out  1  level <= AEMPTY_THRESH
- level  out  ADDR_WIDTH+1  words held (0..DEPTH)
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset (rst=1) or clr: pointers, level, valid, overflow, underflow and dout go to 0. Therefore empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0). Memory contents are not reset.
- clr has priority over any wr_en/rd_en in the same cycle. Both are dropped.
- Write is accepted iff wr_en && !full. The word is stored at wr_ptr and wr_ptr increments mod 2*DEPTH (extra wrap bit).
- wr_en && full: the write is dropped and overflow is set. It stays set until rst or clr.
- Standard mode (FWFT=0):
  - A read is accepted iff rd_en && !empty. On the next edge dout loads mem[rd_ptr] and valid pulses high for exactly one cycle.
  - Otherwise dout holds its value and valid=0.
  - empty = (level == 0).
- FWFT mode (FWFT=1):
  - A one-word output register holds the head word. valid=1 means dout is the head. empty = !valid.
  - rd_en && valid pops the head. The register reloads from memory in the same edge if memory is non-empty; otherwise valid drops.
  - Whenever valid=0 and memory is non-empty, the register loads automatically.
  - level counts memory words plus the output register. Capacity is DEPTH in total.
- Underflow: rd_en && empty sets underflow (sticky). Pointers are unchanged.
- Simultaneous write and read:
  - When neither is blocked, both are accepted and level is unchanged.
  - When full, the write is still blocked even if a read occurs in the same cycle.
  - When empty, the read is blocked while the write proceeds.
- Width rules:
  - level = wr_ptr − rd_ptr, ADDR_WIDTH+1 bits, modular, with the FWFT correction above.
  - Thresholds are compared unsigned against level.

## Timing
- All status outputs (full, empty, almost_*, level, overflow, underflow) reflect the state after the most recent edge. There is no combinational path from wr_en/rd_en to any output.
- Standard mode: a read accepted at edge k presents dout/valid after edge k (1-cycle latency).
- Standard mode: a write at edge k makes empty=0 after edge k, so the word can be read from edge k+1.
- FWFT mode: a write into an empty FIFO at edge k gives valid=1 and dout=word after edge k+1.
- FWFT mode: back-to-back pops sustain 1 word/cycle.
- Throughput is one write and one read per cycle.

## Structure
- Shared package `iis_fifo_pkg`:
  - default DATA_WIDTH/ADDR_WIDTH constants
  - FWFT mode encodings (FIFO_STD, FIFO_FWFT)
- Sub-module `iis_fifo_ram`: simple dual-port, one write port, asynchronous-read port, no reset. This keeps block-RAM/register-file inference separate from the control logic.
- Pointer, level, flag and FWFT output-stage logic live in iis_sync_fifo.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=2 (DEPTH=4), AFULL_THRESH=3 and AEMPTY_THRESH=1 unless noted.
- Reset:
  - Stimulus: assert rst mid-burst after writing 0x0011, 0x0022.
  - Required: immediately level=0, empty=1, full=0, dout=0x0000, valid=0, overflow=0.
- Fill and overflow (FWFT=0):
  - Stimulus: write 0xA000..0xA003, then one more write of 0xA004.
  - Required: full=1 and level=4 after the 4th write; almost_full=1 from level 3.
  - Required: the 5th write is dropped and overflow=1 sticks.
  - Required: reading back gives 0xA000..0xA003, each with a one-cycle valid pulse.
- Underflow and wrap:
  - Stimulus: rd_en on the empty FIFO, then 6 write/read pairs 0x0001..0x0006.
  - Required: underflow=1 and level stays 0 after the empty read.
  - Required: after wrapping past address 3 the data is in order and the final level=0.
- Simultaneous read/write at full:
  - Stimulus: fill with 1..4, then one cycle of wr_en=rd_en=1 with din=5.
  - Required: the read returns 1, the write is dropped, level=3, overflow=1.
- FWFT:
  - Stimulus: FWFT=1, write 0xBEEF at edge k.
  - Required: dout=0xBEEF and valid=1 after edge k+1.
  - Stimulus: write 0xCAFE, then hold rd_en for 2 cycles.
  - Required: pops 0xBEEF then 0xCAFE, after which valid=0, empty=1, level=0.
- clr priority:
  - Stimulus: with level=3, assert clr together with wr_en.
  - Required: level=0, empty=1, both sticky flags cleared, and the write is not stored.

Source files
------------

// File: rtl/iis_fifo_pkg.sv
// Shared definitions for the IIS sample FIFO family: default geometry and
// the read-mode encodings used to select standard or first-word-fall-through.
package iis_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 10;

    // Read-side behaviour of the FIFO output stage.
    typedef enum bit {
        FIFO_STD  = 1'b0,   // registered read, one-cycle valid pulse
        FIFO_FWFT = 1'b1    // head word presented before it is requested
    } fifo_mode_e;

    // Map the integer FWFT parameter onto the mode encoding.
    function automatic fifo_mode_e fifo_mode(input int fwft);
        return (fwft != 0) ? FIFO_FWFT : FIFO_STD;
    endfunction

endpackage

// File: rtl/iis_fifo_ram.sv
// Simple dual-port storage for the sample FIFO: one synchronous write port,
// one asynchronous read port. Kept free of control logic so the tools can map
// it onto a register file or distributed RAM.
module iis_fifo_ram #(
    parameter int DATA_WIDTH = iis_fifo_pkg::DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = iis_fifo_pkg::DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the incoming word on an accepted write.
    // NOTE: no reset on the array -- a reset would turn it into flops with a
    // reset tree and block RAM inference; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/iis_sync_fifo.sv
// Single-clock sample FIFO between the IIS serialiser/deserialiser and the
// APB register logic. Pointers carry one extra wrap bit so that full and
// empty are distinguishable; in FWFT mode a one-word output register holds
// the head and is counted in the occupancy.
module iis_sync_fifo
    import iis_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 2 ** ADDR_WIDTH - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam fifo_mode_e            MODE       = fifo_mode(FWFT);
    localparam int                    DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_LVL  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0]   AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // State
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic                  underflow_q;

    // Decoded control, all derived from registered state plus this cycle's requests
    logic [ADDR_WIDTH:0]   mem_cnt;
    logic [ADDR_WIDTH:0]   level_c;
    logic                  empty_c;
    logic                  full_c;
    logic                  wr_ok;
    logic                  rd_adv;
    logic                  valid_nxt;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Word storage; a flush in the same cycle suppresses the write.
    iis_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok && !clr),
        .waddr (wr_ptr[ADDR_WIDTH-1:0]),
        .wdata (din),
        .raddr (rd_ptr[ADDR_WIDTH-1:0]),
        .rdata (ram_rdata)
    );

    // Occupancy, status and read/write acceptance for the selected read mode.
    // NOTE: every signal gets a value before any branch, so no path leaves one
    // unassigned and no latch is inferred; '=' is right here because this is
    // combinational evaluation, not state.
    always_comb begin
        mem_cnt   = wr_ptr - rd_ptr;
        level_c   = mem_cnt;
        empty_c   = (mem_cnt == '0);
        rd_adv    = 1'b0;
        valid_nxt = 1'b0;
        if (MODE == FIFO_FWFT) begin
            // The output register is part of the capacity and of the level.
            level_c   = mem_cnt + {{ADDR_WIDTH{1'b0}}, valid_q};
            empty_c   = !valid_q;
            // Refill the head register when it is free or being popped.
            rd_adv    = (!valid_q || rd_en) && (mem_cnt != '0);
            valid_nxt = rd_adv || (valid_q && !rd_en);
        end else begin
            rd_adv    = rd_en && !empty_c;
            valid_nxt = rd_adv;
        end
        full_c = (level_c == DEPTH_LVL);
        wr_ok  = wr_en && !full_c;
    end

    // Pointers, output stage and sticky error flags; flush overrides traffic.
    // NOTE: state is updated with '<=' so every register samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (clr) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                dout_q <= ram_rdata;
            end
            valid_q <= valid_nxt;
            if (wr_en && full_c) begin
                overflow_q <= 1'b1;
            end
            if (rd_en && empty_c) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign dout         = dout_q;
    assign valid        = valid_q;
    assign level        = level_c;
    assign full         = full_c;
    assign empty        = empty_c;
    assign almost_full  = (level_c >= AFULL_LVL);
    assign almost_empty = (level_c <= AEMPTY_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_iis_sync_fifo.sv
// Directed bench for iis_sync_fifo: a standard-mode and an FWFT-mode instance
// (DEPTH=4, AFULL=3, AEMPTY=1) share one stimulus stream; each step checks the
// instance whose behaviour it targets against hand-computed values.
module tb_iis_sync_fifo;

    localparam int DW = 16;
    localparam int AW = 2;

    logic          clk;
    logic          rst;
    logic          clr;
    logic          wr_en;
    logic [DW-1:0] din;
    logic          rd_en;

    logic [DW-1:0] s_dout,  f_dout;
    logic          s_valid, f_valid;
    logic          s_full,  f_full;
    logic          s_empty, f_empty;
    logic          s_afull, f_afull;
    logic          s_aempty, f_aempty;
    logic [AW:0]   s_level, f_level;
    logic          s_ovf,   f_ovf;
    logic          s_udf,   f_udf;

    int n_cmp = 0;
    int n_err = 0;

    iis_sync_fifo #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (0),
        .AFULL_THRESH (3), .AEMPTY_THRESH (1)
    ) u_std (
        .clk (clk), .rst (rst), .clr (clr), .wr_en (wr_en), .din (din),
        .rd_en (rd_en), .dout (s_dout), .valid (s_valid), .full (s_full),
        .empty (s_empty), .almost_full (s_afull), .almost_empty (s_aempty),
        .level (s_level), .overflow (s_ovf), .underflow (s_udf)
    );

    iis_sync_fifo #(
        .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .FWFT (1),
        .AFULL_THRESH (3), .AEMPTY_THRESH (1)
    ) u_fwft (
        .clk (clk), .rst (rst), .clr (clr), .wr_en (wr_en), .din (din),
        .rd_en (rd_en), .dout (f_dout), .valid (f_valid), .full (f_full),
        .empty (f_empty), .almost_full (f_afull), .almost_empty (f_aempty),
        .level (f_level), .overflow (f_ovf), .underflow (f_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs set afterwards apply at the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        tick();
        tick();
        rst = 1'b0;

        // ---- Reset mid-burst ----
        wr_en = 1'b1; din = 16'h0011; tick();
        din = 16'h0022; tick();
        wr_en = 1'b0;
        check("pre_rst_level", 32'(s_level), 32'd2);
        check("pre_rst_fwft_dout", 32'(f_dout), 32'h0011);
        rst = 1'b1;
        #1;
        check("rst_level",    32'(s_level), 32'd0);
        check("rst_empty",    32'(s_empty), 32'd1);
        check("rst_full",     32'(s_full),  32'd0);
        check("rst_dout",     32'(s_dout),  32'h0000);
        check("rst_valid",    32'(s_valid), 32'd0);
        check("rst_overflow", 32'(s_ovf),   32'd0);
        check("rst_aempty",   32'(s_aempty), 32'd1);
        check("rst_fwft_dout",  32'(f_dout),  32'h0000);
        check("rst_fwft_valid", 32'(f_valid), 32'd0);
        tick();
        rst = 1'b0;

        // ---- Fill and overflow (standard) ----
        wr_en = 1'b1; din = 16'hA000; tick();
        check("fill1_level", 32'(s_level), 32'd1);
        check("fill1_aempty", 32'(s_aempty), 32'd1);
        check("fill1_valid", 32'(s_valid), 32'd0);
        din = 16'hA001; tick();
        check("fill2_afull", 32'(s_afull), 32'd0);
        check("fill2_aempty", 32'(s_aempty), 32'd0);
        din = 16'hA002; tick();
        check("fill3_afull", 32'(s_afull), 32'd1);
        check("fill3_full",  32'(s_full),  32'd0);
        din = 16'hA003; tick();
        check("fill4_full",  32'(s_full),  32'd1);
        check("fill4_level", 32'(s_level), 32'd4);
        check("fill4_ovf",   32'(s_ovf),   32'd0);
        din = 16'hA004; tick();
        wr_en = 1'b0;
        check("ovf_level", 32'(s_level), 32'd4);
        check("ovf_flag",  32'(s_ovf),   32'd1);
        rd_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rb_dout",  32'(s_dout),  32'hA000 + 32'(i));
            check("rb_valid", 32'(s_valid), 32'd1);
            check("rb_level", 32'(s_level), 32'(3 - i));
        end
        rd_en = 1'b0;
        tick();
        check("rb_valid_drop", 32'(s_valid), 32'd0);
        check("rb_dout_hold",  32'(s_dout),  32'hA003);
        check("rb_empty",      32'(s_empty), 32'd1);
        check("ovf_sticky",    32'(s_ovf),   32'd1);
        check("rb_no_udf",     32'(s_udf),   32'd0);

        // ---- Underflow and wrap ----
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        check("udf_flag",  32'(s_udf),   32'd1);
        check("udf_level", 32'(s_level), 32'd0);
        check("udf_valid", 32'(s_valid), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            wr_en = 1'b1; din = 16'(i); tick();
            wr_en = 1'b0; rd_en = 1'b1; tick();
            rd_en = 1'b0;
            check("wrap_dout",  32'(s_dout),  32'(i));
            check("wrap_valid", 32'(s_valid), 32'd1);
        end
        check("wrap_level", 32'(s_level), 32'd0);
        check("wrap_empty", 32'(s_empty), 32'd1);

        // ---- Flush, then simultaneous read/write at full ----
        clr = 1'b1; tick();
        clr = 1'b0;
        check("clr_ovf", 32'(s_ovf), 32'd0);
        check("clr_udf", 32'(s_udf), 32'd0);
        wr_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            din = 16'(i); tick();
        end
        check("sim_full", 32'(s_full), 32'd1);
        rd_en = 1'b1; din = 16'd5; tick();
        wr_en = 1'b0; rd_en = 1'b0;
        check("sim_dout",  32'(s_dout),  32'd1);
        check("sim_valid", 32'(s_valid), 32'd1);
        check("sim_level", 32'(s_level), 32'd3);
        check("sim_ovf",   32'(s_ovf),   32'd1);
        rd_en = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("sim_drain", 32'(s_dout), 32'(i));
        end
        rd_en = 1'b0;
        check("sim_drain_level", 32'(s_level), 32'd0);

        // ---- FWFT ----
        rst = 1'b1; #1; rst = 1'b0;
        wr_en = 1'b1; din = 16'hBEEF; tick();          // edge k
        check("fwft_k_valid", 32'(f_valid), 32'd0);
        check("fwft_k_level", 32'(f_level), 32'd1);
        check("fwft_k_empty", 32'(f_empty), 32'd1);
        din = 16'hCAFE; tick();                          // edge k+1
        wr_en = 1'b0;
        check("fwft_head_dout",  32'(f_dout),  32'hBEEF);
        check("fwft_head_valid", 32'(f_valid), 32'd1);
        check("fwft_head_level", 32'(f_level), 32'd2);
        rd_en = 1'b1; tick();
        check("fwft_pop1_dout",  32'(f_dout),  32'hCAFE);
        check("fwft_pop1_valid", 32'(f_valid), 32'd1);
        check("fwft_pop1_level", 32'(f_level), 32'd1);
        tick();
        rd_en = 1'b0;
        check("fwft_pop2_valid", 32'(f_valid), 32'd0);
        check("fwft_pop2_empty", 32'(f_empty), 32'd1);
        check("fwft_pop2_level", 32'(f_level), 32'd0);
        check("fwft_pop2_udf",   32'(f_udf),   32'd0);

        // ---- clr priority over a write, with both sticky flags set ----
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = 16'h0070 + 16'(i); tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b1; tick();
        rd_en = 1'b0;
        check("pre_clr_level", 32'(s_level), 32'd3);
        check("pre_clr_udf",   32'(s_udf),   32'd1);
        check("pre_clr_ovf",   32'(s_ovf),   32'd1);
        check("pre_clr_fwft_level", 32'(f_level), 32'd3);
        check("pre_clr_fwft_ovf",   32'(f_ovf),   32'd1);
        clr = 1'b1; wr_en = 1'b1; din = 16'hDEAD; tick();
        clr = 1'b0; wr_en = 1'b0;
        check("clr_level", 32'(s_level), 32'd0);
        check("clr_empty", 32'(s_empty), 32'd1);
        check("clr_ovf2",  32'(s_ovf),   32'd0);
        check("clr_udf2",  32'(s_udf),   32'd0);
        check("clr_dout",  32'(s_dout),  32'h0000);
        check("clr_fwft_level", 32'(f_level), 32'd0);
        check("clr_fwft_udf",   32'(f_udf),   32'd0);
        tick();
        check("clr_no_write",      32'(s_level), 32'd0);
        check("clr_fwft_no_write", 32'(f_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
